hdlc_rx_monitor: RTL and testbench

Synthesizable, parametrised protocol monitor for the HDLC receive path; it replaces bind-only concurrent assertions with a checker that runs in simulation, emulation and FPGA debug builds. It observes the serial Rx line and the Rx status strobes, tracks each protocol expectation in fixed-latency pipelines, and reports violations through per-check error pulses, sticky flags and saturating counters. It sits beside the Rx block and has no outputs back into the datapath.

---
 rtl/hdlc_rx_monitor.sv | 154 +++++++++++++++
 tb/tb_hdlc_rx_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_monitor.sv
// HDLC receive-path protocol monitor: per-check error pulses, sticky flags and saturating counters.
// Optional HDLC_MON_DISPLAY_EN adds simulation-only PASS/failure messages; registers are identical either way.
module hdlc_rx_monitor #(
  parameter int unsigned FLAG_LATENCY  = 2,
  parameter int unsigned ABORT_LATENCY = 1,
  parameter int unsigned EOF_LATENCY   = 1,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Rx,
  input  logic                       Rx_FlagDetect,
  input  logic                       Rx_AbortDetect,
  input  logic                       Rx_AbortSignal,
  input  logic                       Rx_ValidFrame,
  input  logic                       Rx_EoF,
  input  logic                       Rx_WrBuff,
  input  logic [3:0]                 Chk_En,
  input  logic                       Clear,
  output logic [3:0]                 Err_Pulse,
  output logic [3:0]                 Err_Sticky,
  output logic [4*CNT_WIDTH-1:0]     ErrCnt,
  output logic [CNT_WIDTH+1:0]       ErrTotal
);

  localparam int unsigned TOT_WIDTH = CNT_WIDTH + 2;
  localparam int unsigned SUM_WIDTH = TOT_WIDTH + 1;
  localparam logic [7:0]  FLAG_PATTERN = 8'h7E;
  localparam logic [3:0]  FILL_FULL    = 4'd8;

  logic [7:0]                      shift_q, shift_d;
  logic [3:0]                      fill_q, fill_d;
  logic [FLAG_LATENCY-1:0]         flag_pipe_q, flag_pipe_d;
  logic [ABORT_LATENCY-1:0]        abort_pipe_q, abort_pipe_d;
  logic [EOF_LATENCY-1:0]          eof_pipe_q, eof_pipe_d;
  logic                            vf_prev_q, vf_prev_d;
  logic [3:0]                      err_pulse_q, err_pulse_d;
  logic [3:0]                      err_sticky_q, err_sticky_d;
  logic [3:0][CNT_WIDTH-1:0]       err_cnt_q, err_cnt_d;
  logic [TOT_WIDTH-1:0]            err_total_q, err_total_d;

  logic                            flag_match_c;
  logic [3:0]                      fail_c;
  logic [2:0]                      fail_num_c;
  logic [SUM_WIDTH-1:0]            total_sum_c;

  // Expectation tracking: shift register, fill counter and latency pipelines
  always_comb begin
    shift_d      = {shift_q[6:0], Rx};
    fill_d       = (fill_q == FILL_FULL) ? fill_q : fill_q + 4'd1;
    flag_match_c = (fill_q == FILL_FULL) && (shift_q == FLAG_PATTERN);
    vf_prev_d    = Rx_ValidFrame;

    flag_pipe_d     = flag_pipe_q;
    flag_pipe_d[0]  = flag_match_c;
    for (int i = 1; i < int'(FLAG_LATENCY); i++) flag_pipe_d[i] = flag_pipe_q[i-1];

    abort_pipe_d    = abort_pipe_q;
    abort_pipe_d[0] = Rx_AbortDetect && Rx_ValidFrame;
    for (int i = 1; i < int'(ABORT_LATENCY); i++) abort_pipe_d[i] = abort_pipe_q[i-1];

    eof_pipe_d      = eof_pipe_q;
    eof_pipe_d[0]   = vf_prev_q && !Rx_ValidFrame;
    for (int i = 1; i < int'(EOF_LATENCY); i++) eof_pipe_d[i] = eof_pipe_q[i-1];
  end

  // Enables gate only the evaluation point; tokens keep flowing regardless
  always_comb begin
    fail_c[0] = flag_pipe_q[FLAG_LATENCY-1]   && !Rx_FlagDetect  && Chk_En[0];
    fail_c[1] = abort_pipe_q[ABORT_LATENCY-1] && !Rx_AbortSignal && Chk_En[1];
    fail_c[2] = eof_pipe_q[EOF_LATENCY-1]     && !Rx_EoF         && Chk_En[2];
    fail_c[3] = Rx_WrBuff && !Rx_ValidFrame   && Chk_En[3];
    fail_num_c  = 3'(fail_c[0]) + 3'(fail_c[1]) + 3'(fail_c[2]) + 3'(fail_c[3]);
    total_sum_c = {1'b0, err_total_q} + SUM_WIDTH'(fail_num_c);
  end

  // Reporting: pulses always fire; Clear wins over same-cycle count/sticky updates
  always_comb begin
    err_pulse_d  = fail_c;
    err_sticky_d = err_sticky_q | fail_c;
    err_cnt_d    = err_cnt_q;
    err_total_d  = total_sum_c[SUM_WIDTH-1] ? '1 : total_sum_c[TOT_WIDTH-1:0];
    for (int k = 0; k < 4; k++) begin
      if (fail_c[k] && (err_cnt_q[k] != '1)) err_cnt_d[k] = err_cnt_q[k] + CNT_WIDTH'(1);
    end
    if (Clear) begin
      err_sticky_d = '0;
      err_cnt_d    = '0;
      err_total_d  = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      shift_q      <= '0;
      fill_q       <= '0;
      flag_pipe_q  <= '0;
      abort_pipe_q <= '0;
      eof_pipe_q   <= '0;
      vf_prev_q    <= 1'b0;
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
      err_cnt_q    <= '0;
      err_total_q  <= '0;
    end else begin
      shift_q      <= shift_d;
      fill_q       <= fill_d;
      flag_pipe_q  <= flag_pipe_d;
      abort_pipe_q <= abort_pipe_d;
      eof_pipe_q   <= eof_pipe_d;
      vf_prev_q    <= vf_prev_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      err_total_q  <= err_total_d;
    end
  end

  assign Err_Pulse  = err_pulse_q;
  assign Err_Sticky = err_sticky_q;
  assign ErrCnt     = err_cnt_q;
  assign ErrTotal   = err_total_q;

`ifdef HDLC_MON_DISPLAY_EN
  logic [3:0] pass_c;

  always_comb begin
    pass_c[0] = flag_pipe_q[FLAG_LATENCY-1]   && Rx_FlagDetect  && Chk_En[0];
    pass_c[1] = abort_pipe_q[ABORT_LATENCY-1] && Rx_AbortSignal && Chk_En[1];
    pass_c[2] = eof_pipe_q[EOF_LATENCY-1]     && Rx_EoF         && Chk_En[2];
    pass_c[3] = Rx_WrBuff && Rx_ValidFrame    && Chk_En[3];
  end

  function automatic string check_name(input int k);
    case (k)
      0:       return "flag";
      1:       return "abort";
      2:       return "eof";
      default: return "write";
    endcase
  endfunction

  // Messages print on the edge that loads Err_Pulse
  always @(posedge Clk) begin
    if (!Rst) begin
      for (int k = 0; k < 4; k++) begin
        if (fail_c[k])      $error("hdlc_rx_monitor: %s check violated", check_name(k));
        else if (pass_c[k]) $display("PASS: %s", check_name(k));
      end
    end
  end
`endif

endmodule

// File: tb/tb_hdlc_rx_monitor.sv
// Directed bench for hdlc_rx_monitor, built with CNT_WIDTH=4 so counter saturation is reachable.
module tb_hdlc_rx_monitor;

  localparam int unsigned CW = 4;

  logic              Clk, Rst, Rx;
  logic              Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal;
  logic              Rx_ValidFrame, Rx_EoF, Rx_WrBuff;
  logic [3:0]        Chk_En;
  logic              Clear;
  logic [3:0]        Err_Pulse, Err_Sticky;
  logic [4*CW-1:0]   ErrCnt;
  logic [CW+1:0]     ErrTotal;

  int checks = 0;
  int errors = 0;

  hdlc_rx_monitor #(
    .FLAG_LATENCY(2), .ABORT_LATENCY(1), .EOF_LATENCY(1), .CNT_WIDTH(CW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_EoF(Rx_EoF), .Rx_WrBuff(Rx_WrBuff), .Chk_En(Chk_En), .Clear(Clear),
    .Err_Pulse(Err_Pulse), .Err_Sticky(Err_Sticky), .ErrCnt(ErrCnt), .ErrTotal(ErrTotal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts 0,1,1,1,1,1,1,0 onto Rx; returns in the cycle the match is visible
  task automatic send_flag();
    logic [7:0] pat;
    pat = 8'h7E;
    for (int i = 7; i >= 0; i--) begin
      Rx = pat[i];
      tick();
    end
    Rx = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt(input int k);
    return ErrCnt[k*CW +: CW];
  endfunction

  initial begin
    Rst = 1'b1; Rx = 1'b0; Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0;
    Rx_AbortSignal = 1'b0; Rx_ValidFrame = 1'b0; Rx_EoF = 1'b0; Rx_WrBuff = 1'b0;
    Chk_En = 4'hF; Clear = 1'b0;
    tick(); tick();
    check("rst_pulse",  64'(Err_Pulse),  64'h0);
    check("rst_sticky", 64'(Err_Sticky), 64'h0);
    check("rst_cnt",    64'(ErrCnt),     64'h0);
    check("rst_total",  64'(ErrTotal),   64'h0);
    Rst = 1'b0;

    // Flag answered two cycles after the match
    send_flag();
    tick();
    tick(); Rx_FlagDetect = 1'b1;
    tick(); Rx_FlagDetect = 1'b0;
    check("flag_ok_pulse", 64'(Err_Pulse), 64'h0);
    check("flag_ok_cnt",   64'(cnt(0)),    64'h0);

    // Flag never answered
    send_flag();
    tick();
    tick();
    check("flag_bad_pre", 64'(Err_Pulse), 64'h0);
    tick();
    check("flag_bad_pulse",  64'(Err_Pulse),  64'h1);
    check("flag_bad_cnt",    64'(cnt(0)),     64'h1);
    check("flag_bad_sticky", 64'(Err_Sticky), 64'h1);
    check("flag_bad_total",  64'(ErrTotal),   64'h1);
    tick();
    check("flag_bad_once", 64'(Err_Pulse), 64'h0);

    // Abort inside a frame without Rx_AbortSignal
    Rx_ValidFrame = 1'b1; tick();
    Rx_AbortDetect = 1'b1; tick();
    Rx_AbortDetect = 1'b0; tick();
    check("abort_pulse", 64'(Err_Pulse), 64'h2);
    check("abort_cnt",   64'(cnt(1)),    64'h1);
    check("abort_total", 64'(ErrTotal),  64'h2);

    // Frame ends without Rx_EoF; abort seen outside a frame is ignored
    Rx_ValidFrame = 1'b0; Rx_AbortDetect = 1'b1; tick();
    Rx_AbortDetect = 1'b0;
    check("eof_bad_pre", 64'(Err_Pulse), 64'h0);
    tick();
    check("eof_bad_pulse",  64'(Err_Pulse), 64'h4);
    check("eof_bad_cnt",    64'(cnt(2)),    64'h1);
    check("abort_noframe",  64'(cnt(1)),    64'h1);
    check("eof_bad_total",  64'(ErrTotal),  64'h3);

    // Frame ends with Rx_EoF one cycle later
    Rx_ValidFrame = 1'b1; tick();
    Rx_ValidFrame = 1'b0; tick();
    Rx_EoF = 1'b1; tick();
    Rx_EoF = 1'b0;
    check("eof_ok_pulse", 64'(Err_Pulse), 64'h0);
    check("eof_ok_cnt",   64'(cnt(2)),    64'h1);
    check("eof_ok_total", 64'(ErrTotal),  64'h3);

    // Abort failure and write-outside-frame together
    Rx_ValidFrame = 1'b1; Rx_AbortDetect = 1'b1; tick();
    Rx_ValidFrame = 1'b0; Rx_AbortDetect = 1'b0; Rx_WrBuff = 1'b1; tick();
    Rx_WrBuff = 1'b0; Rx_EoF = 1'b1;
    check("dual_pulse",  64'(Err_Pulse),  64'hA);
    check("dual_cnt1",   64'(cnt(1)),     64'h2);
    check("dual_cnt3",   64'(cnt(3)),     64'h1);
    check("dual_total",  64'(ErrTotal),   64'h5);
    check("dual_sticky", 64'(Err_Sticky), 64'hF);
    tick();
    Rx_EoF = 1'b0;
    check("dual_after", 64'(Err_Pulse), 64'h0);

    // Same double failure with Clear in the failing cycle
    Rx_ValidFrame = 1'b1; Rx_AbortDetect = 1'b1; tick();
    Rx_ValidFrame = 1'b0; Rx_AbortDetect = 1'b0; Rx_WrBuff = 1'b1; Clear = 1'b1; tick();
    Rx_WrBuff = 1'b0; Clear = 1'b0; Rx_EoF = 1'b1;
    check("clr_pulse",  64'(Err_Pulse),  64'hA);
    check("clr_sticky", 64'(Err_Sticky), 64'h0);
    check("clr_cnt",    64'(ErrCnt),     64'h0);
    check("clr_total",  64'(ErrTotal),   64'h0);
    tick();
    Rx_EoF = 1'b0;

    // Twenty overlapping flags, none answered
    Rx = 1'b0; tick();
    for (int f = 0; f < 20; f++) begin
      for (int b = 0; b < 6; b++) begin
        Rx = 1'b1; tick();
      end
      Rx = 1'b0; tick();
    end
    for (int d = 0; d < 4; d++) tick();
    check("sat_cnt",    64'(cnt(0)),     64'hF);
    check("sat_total",  64'(ErrTotal),   64'd20);
    check("sat_sticky", 64'(Err_Sticky), 64'h1);

    Clear = 1'b1; tick();
    Clear = 1'b0;
    check("clear_cnt",    64'(ErrCnt),     64'h0);
    check("clear_total",  64'(ErrTotal),   64'h0);
    check("clear_sticky", 64'(Err_Sticky), 64'h0);

    // Enable is sampled at evaluation: disabled at push, enabled at evaluation
    Chk_En = 4'hE;
    send_flag();
    tick(); Chk_En = 4'hF;
    tick();
    tick();
    check("en_eval_pulse", 64'(Err_Pulse), 64'h1);
    check("en_eval_cnt",   64'(cnt(0)),    64'h1);

    // Enabled at push, disabled at evaluation
    send_flag();
    tick();
    tick(); Chk_En = 4'hE;
    tick(); Chk_En = 4'hF;
    check("en_off_pulse", 64'(Err_Pulse), 64'h0);
    check("en_off_cnt",   64'(cnt(0)),    64'h1);

    // Reset with a flag token in flight
    send_flag();
    tick(); Rst = 1'b1;
    tick(); Rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_mid_pulse", 64'(Err_Pulse), 64'h0);
    end
    check("rst_mid_cnt",    64'(ErrCnt),     64'h0);
    check("rst_mid_sticky", 64'(Err_Sticky), 64'h0);
    check("rst_mid_total",  64'(ErrTotal),   64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
